// File: rtl/ram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_ctrl_pkg
//  Description : Shared types and default widths for the RAM access arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_ctrl_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 4;

  typedef enum logic {CLEAR, SERVE} ctrl_state_t;

  typedef enum logic {PORT_A, PORT_B} port_t;

endpackage : ram_ctrl_pkg
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-port round-robin arbiter; pointer toggles after a grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
  import ram_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_a,
  input  logic req_b,
  input  logic enable,
  output logic gnt_a,
  output logic gnt_b
);

  port_t r_ptr;

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    gnt_a = enable & req_a & (~req_b | (r_ptr == PORT_A));
    gnt_b = enable & req_b & (~req_a | (r_ptr == PORT_B));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ptr <= PORT_A;
    end else if (gnt_a) begin
      r_ptr <= PORT_B;
    end else if (gnt_b) begin
      r_ptr <= PORT_A;
    end
  end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/ram_access_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_access_arbiter
//  Description : Shares one single-port synchronous RAM between two requesters,
//                with array clear after reset or on demand.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_access_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int                ADDR_W         = ADDR_W_DEF,
  parameter int                DATA_W         = DATA_W_DEF,
  parameter logic [DATA_W-1:0] CLEAR_VAL      = '0,
  parameter bit                CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  input  logic              req_a,
  input  logic              wr_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              gnt_a,
  output logic              rvalid_a,
  input  logic              req_b,
  input  logic              wr_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_b,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [ADDR_W-1:0] c_last_addr   = '1;
  localparam ctrl_state_t       c_reset_state = CLEAR_ON_RESET ? CLEAR : SERVE;

  ctrl_state_t       r_state;
  ctrl_state_t       w_state_nxt;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [ADDR_W-1:0] r_last_addr;
  logic              r_rvalid_a;
  logic              r_rvalid_b;
  logic              w_arb_en;
  logic              w_gnt_a;
  logic              w_gnt_b;

  // A clear request in SERVE suppresses grants for that cycle.
  assign w_arb_en = (r_state == SERVE) & ~clear_req;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req_a  (req_a),
    .req_b  (req_b),
    .enable (w_arb_en),
    .gnt_a  (w_gnt_a),
    .gnt_b  (w_gnt_b)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= c_reset_state;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = r_last_addr;
    ram_wdata   = CLEAR_VAL;
    case (r_state)
      CLEAR: begin
        busy     = 1'b1;
        ram_we   = 1'b1;
        ram_addr = r_clr_cnt;
        if (r_clr_cnt == c_last_addr) begin
          w_state_nxt = SERVE;
        end
      end
      SERVE: begin
        if (clear_req) begin
          w_state_nxt = CLEAR;
        end else if (w_gnt_a) begin
          ram_we    = wr_a;
          ram_addr  = addr_a;
          ram_wdata = wdata_a;
        end else if (w_gnt_b) begin
          ram_we    = wr_b;
          ram_addr  = addr_b;
          ram_wdata = wdata_b;
        end
      end
      default: begin
        w_state_nxt = c_reset_state;
      end
    endcase
  end

  // ram_addr is remembered so idle SERVE cycles keep the address bus steady.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_clr_cnt   <= '0;
      r_last_addr <= '0;
      r_rvalid_a  <= 1'b0;
      r_rvalid_b  <= 1'b0;
    end else begin
      r_clr_cnt   <= (r_state == CLEAR) ? r_clr_cnt + 1'b1 : '0;
      r_last_addr <= ram_addr;
      r_rvalid_a  <= w_gnt_a & ~wr_a;
      r_rvalid_b  <= w_gnt_b & ~wr_b;
    end
  end

  assign gnt_a    = w_gnt_a;
  assign gnt_b    = w_gnt_b;
  assign rvalid_a = r_rvalid_a;
  assign rvalid_b = r_rvalid_b;
  assign rdata    = ram_rdata;

endmodule : ram_access_arbiter
`default_nettype wire

// File: tb/tb_ram_access_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_access_arbiter
//  Description : Bench pairing the arbiter with a 32x4 synchronous RAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_access_arbiter;

  logic       clk = 1'b0;
  logic       reset, clear_req;
  logic       req_a, wr_a, req_b, wr_b;
  logic [4:0] addr_a, addr_b;
  logic [3:0] wdata_a, wdata_b;
  logic       gnt_a, gnt_b, rvalid_a, rvalid_b, busy, ram_we;
  logic [3:0] rdata, ram_wdata, ram_rdata;
  logic [4:0] ram_addr;

  always #5 clk = ~clk;

  ram_access_arbiter dut (
    .clk(clk), .reset(reset), .clear_req(clear_req),
    .req_a(req_a), .wr_a(wr_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a),
    .req_b(req_b), .wr_b(wr_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b),
    .rdata(rdata), .busy(busy), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // 32x4 RAM: registered read of last cycle's address, old data on write
  logic [3:0] ram_mem [32];
  initial for (int i = 0; i < 32; i++) ram_mem[i] = 4'hF;
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: clear countdown, tie-break flag, word array, pending read.
  bit         model_on   = 1'b0;
  int         clear_left = 32;
  bit         turn_b     = 1'b0;
  int         last_addr  = 0;
  bit         erv_a      = 1'b0;
  bit         erv_b      = 1'b0;
  logic [3:0] erd        = 4'h0;
  logic [3:0] mem_m [32];
  initial for (int i = 0; i < 32; i++) mem_m[i] = 4'hF;

  always @(negedge clk) begin : p_model
    bit         ea, eb, ewe;
    int         eaddr;
    logic [3:0] ewd;
    ea = 1'b0; eb = 1'b0; ewe = 1'b0; eaddr = last_addr; ewd = 4'h0;
    if (clear_left > 0) begin
      ewe = 1'b1; eaddr = 32 - clear_left; ewd = 4'h0;
    end else if (!clear_req) begin
      if (req_a && (!req_b || !turn_b)) ea = 1'b1;
      else if (req_b) eb = 1'b1;
      if (ea) begin ewe = wr_a; eaddr = addr_a; ewd = wdata_a; end
      else if (eb) begin ewe = wr_b; eaddr = addr_b; ewd = wdata_b; end
    end
    if (model_on) begin
      check("m_busy", busy, clear_left > 0);
      check("m_gnt_a", gnt_a, ea);
      check("m_gnt_b", gnt_b, eb);
      check("m_ram_we", ram_we, ewe);
      check("m_ram_addr", ram_addr, eaddr);
      if (ewe) check("m_ram_wdata", ram_wdata, ewd);
      check("m_rvalid_a", rvalid_a, erv_a);
      check("m_rvalid_b", rvalid_b, erv_b);
      if (erv_a || erv_b) check("m_rdata", rdata, erd);
    end
    erv_a = ea && !wr_a;
    erv_b = eb && !wr_b;
    if (erv_a || erv_b) erd = mem_m[eaddr];
    if (ewe) mem_m[eaddr] = ewd;
    if (clear_left > 0) clear_left--;
    else if (clear_req) clear_left = 32;
    else if (ea) turn_b = 1'b1;
    else if (eb) turn_b = 1'b0;
    last_addr = eaddr;
    if (!reset) begin
      clear_left = 32; turn_b = 1'b0; last_addr = 0; erv_a = 1'b0; erv_b = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at a negedge inside CLEAR; returns at the negedge of the first SERVE cycle.
  task automatic wait_clear(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      check("clr_addr", ram_addr, n);
      check("clr_we", ram_we, 1'b1);
      n++;
      @(negedge clk);
    end
  endtask

  task automatic access(input bit pb, input bit wr, input logic [4:0] a, input logic [3:0] d);
    bit got;
    got = 1'b0;
    if (pb) begin req_b = 1'b1; wr_b = wr; addr_b = a; wdata_b = d; end
    else    begin req_a = 1'b1; wr_a = wr; addr_a = a; wdata_a = d; end
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = pb ? gnt_b : gnt_a;
    end
    check("gnt_timeout", got, 1'b1);
    tick();
    if (pb) req_b = 1'b0; else req_a = 1'b0;
  endtask

  task automatic rd(input bit pb, input logic [4:0] a, input logic [3:0] exp);
    access(pb, 1'b0, a, 4'h0);
    @(negedge clk);
    check(pb ? "rd_rvalid_b" : "rd_rvalid_a", pb ? rvalid_b : rvalid_a, 1'b1);
    check(pb ? "rd_rvalid_a_quiet" : "rd_rvalid_b_quiet", pb ? rvalid_a : rvalid_b, 1'b0);
    check("rd_rdata", rdata, exp);
    tick();
  endtask

  initial begin : p_drive
    int  n;
    bit  found;
    reset = 1'b0; clear_req = 1'b0;
    req_a = 1'b0; wr_a = 1'b0; addr_a = '0; wdata_a = '0;
    req_b = 1'b0; wr_b = 1'b0; addr_b = '0; wdata_b = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    model_on = 1'b1;

    // Clear after reset, then read an untouched word
    @(negedge clk);
    wait_clear(n);
    check("clr_len_reset", n, 32);
    tick();
    rd(1'b0, 5'd7, 4'h0);

    // Write then read back on A, and the same word through B
    access(1'b0, 1'b1, 5'd3, 4'hA);
    rd(1'b0, 5'd3, 4'hA);
    rd(1'b1, 5'd3, 4'hA);

    // Simultaneous writes to one address: A first, B overwrites
    req_a = 1'b1; wr_a = 1'b1; addr_a = 5'd5; wdata_a = 4'h3;
    req_b = 1'b1; wr_b = 1'b1; addr_b = 5'd5; wdata_b = 4'hC;
    @(negedge clk);
    check("t4_first_a", {gnt_a, gnt_b}, 2'b10);
    tick();
    req_a = 1'b0;
    @(negedge clk);
    check("t4_second_b", {gnt_a, gnt_b}, 2'b01);
    tick();
    req_b = 1'b0;
    rd(1'b0, 5'd5, 4'hC);

    // Clear request while both ports wait
    req_a = 1'b1; wr_a = 1'b0; addr_a = 5'd3;
    req_b = 1'b1; wr_b = 1'b0; addr_b = 5'd5;
    clear_req = 1'b1;
    @(negedge clk);
    check("t5_no_gnt", {gnt_a, gnt_b, ram_we}, 3'b000);
    tick();
    clear_req = 1'b0;
    @(negedge clk);
    wait_clear(n);
    check("clr_len_req", n, 32);
    check("t5_b_first", {gnt_a, gnt_b}, 2'b01);
    tick();
    req_b = 1'b0;
    @(negedge clk);
    check("t5_a_next", {gnt_a, gnt_b}, 2'b10);
    check("t5_rdata_b", {rvalid_b, rdata}, 5'h10);
    tick();
    req_a = 1'b0;
    @(negedge clk);
    check("t5_rdata_a", {rvalid_a, rdata}, 5'h10);
    tick();

    // Reset while the clear counter is at 17 (pointer currently favours B)
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      found = (busy === 1'b1) && (ram_addr == 5'd16);
      tick();
    end
    check("t6_reach_16", found, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    check("t6_addr_17", ram_addr, 5'd17);
    tick();
    reset = 1'b1;
    req_a = 1'b1; wr_a = 1'b0; addr_a = 5'd3;
    req_b = 1'b1; wr_b = 1'b0; addr_b = 5'd5;
    @(negedge clk);
    check("t6_restart", {busy, ram_addr}, 6'h20);
    wait_clear(n);
    check("clr_len_rst", n, 32);

    // Continuous requests from both ports alternate starting with A
    for (int k = 0; k < 4; k++) begin
      check("t3_alternate", {gnt_a, gnt_b}, (k % 2 == 0) ? 2'b10 : 2'b01);
      tick();
      @(negedge clk);
    end
    tick();
    req_a = 1'b0; req_b = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : p_watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_ram_access_arbiter
`default_nettype wire
